// File: rtl/upg_word_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : upg_word_loader_if
//  Purpose  : Bundles the byte-stream input and the memory programming
//             outputs of the word loader.
//  Signals  : start_i     - arm pulse
//             rx_valid_i  - received-byte strobe
//             rx_data_i   - received byte
//             upg_wen_o   - one-cycle write pulse per word
//             upg_adr_o   - word address (qualified by upg_wen_o)
//             upg_dat_o   - word data    (qualified by upg_wen_o)
//             upg_done_o  - transfer complete
//             err_o       - transfer aborted
//             busy_o      - transfer in progress
//  Modports : master - byte source / memory side
//             slave  - the loader
//  Revision : 1.0 - initial release
// ============================================================================
interface upg_word_loader_if;
    logic        start_i;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        upg_wen_o;
    logic [13:0] upg_adr_o;
    logic [31:0] upg_dat_o;
    logic        upg_done_o;
    logic        err_o;
    logic        busy_o;

    modport master (
        output start_i, rx_valid_i, rx_data_i,
        input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );

    modport slave (
        input  start_i, rx_valid_i, rx_data_i,
        output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, err_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/upg_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : upg_word_loader
//  Purpose  : Parses a 2-byte little-endian word count from the UART byte
//             stream, assembles little-endian 32-bit words and issues one
//             write pulse per word on the memory programming port.
//  Ports    : upg_clk_i   - clock, rising edge
//             upg_rst_n_i - asynchronous active-low reset
//             bus         - upg_word_loader_if.slave (byte in, writes out)
//  Params   : TIMEOUT_CYC - idle cycles tolerated between bytes in LEN_HI/DATA
//             MAX_WORDS   - largest legal word count
//  Revision : 1.0 - initial release
// ============================================================================
module upg_word_loader #(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int MAX_WORDS   = 16384
) (
    input  wire logic        upg_clk_i,
    input  wire logic        upg_rst_n_i,
    upg_word_loader_if.slave bus
);

    localparam int                 TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]   C_TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]   C_TMO_ONE   = TMO_W'(1);
    localparam logic [16:0]        C_MAX_WORDS = 17'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [7:0]       r_cnt_lo;
    logic [15:0]      r_rem;
    logic [13:0]      r_wcnt;
    logic [1:0]       r_bidx;
    logic [23:0]      r_word;     // bytes 0..2 of the word being assembled
    logic [TMO_W-1:0] r_tmo;

    logic             r_wen;
    logic [13:0]      r_adr;
    logic [31:0]      r_dat;
    logic             r_done;
    logic             r_err;
    logic             r_busy;

    logic [15:0]      w_count;
    logic             w_tmo_hit;

    assign w_count   = {bus.rx_data_i, r_cnt_lo};
    // Hitting LAST with no byte this cycle means the next edge is the
    // TIMEOUT_CYC-th idle edge since the last accepted byte.
    assign w_tmo_hit = (r_tmo == C_TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start_i) w_state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (bus.rx_valid_i) w_state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (bus.rx_valid_i) begin
                    if (w_count == 16'd0)                  w_state_nxt = S_DONE;
                    else if ({1'b0, w_count} > C_MAX_WORDS) w_state_nxt = S_ERR;
                    else                                   w_state_nxt = S_DATA;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                if (bus.rx_valid_i) begin
                    if (r_bidx == 2'd3) w_state_nxt = S_WRITE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                if (r_rem == 16'd1) w_state_nxt = S_DONE;
                else                w_state_nxt = S_DATA;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge upg_clk_i or negedge upg_rst_n_i) begin
        if (!upg_rst_n_i) begin
            r_cnt_lo <= '0;
            r_rem    <= '0;
            r_wcnt   <= '0;
            r_bidx   <= '0;
            r_word   <= '0;
            r_tmo    <= '0;
            r_wen    <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            // Status flags follow the state being entered, so they are
            // flop outputs that line up exactly with the state register.
            r_wen  <= (w_state_nxt == S_WRITE);
            r_done <= (w_state_nxt == S_DONE);
            r_err  <= (w_state_nxt == S_ERR);
            r_busy <= (w_state_nxt == S_LEN_LO) || (w_state_nxt == S_LEN_HI) ||
                      (w_state_nxt == S_DATA)   || (w_state_nxt == S_WRITE);

            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start_i) begin
                        r_wcnt <= '0;
                        r_bidx <= '0;
                        r_tmo  <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (bus.rx_valid_i) begin
                        r_cnt_lo <= bus.rx_data_i;
                        r_tmo    <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (bus.rx_valid_i) begin
                        r_rem  <= w_count;
                        r_bidx <= '0;
                        r_tmo  <= '0;
                    end else begin
                        r_tmo <= r_tmo + C_TMO_ONE;
                    end
                end
                S_DATA: begin
                    if (bus.rx_valid_i) begin
                        r_tmo  <= '0;
                        r_bidx <= r_bidx + 2'd1;
                        case (r_bidx)
                            2'd0: r_word[7:0]   <= bus.rx_data_i;
                            2'd1: r_word[15:8]  <= bus.rx_data_i;
                            2'd2: r_word[23:16] <= bus.rx_data_i;
                            default: begin
                                // Capture into separate output registers so
                                // the next word can assemble during WRITE.
                                r_dat <= {bus.rx_data_i, r_word};
                                r_adr <= r_wcnt;
                            end
                        endcase
                    end else begin
                        r_tmo <= r_tmo + C_TMO_ONE;
                    end
                end
                S_WRITE: begin
                    r_wcnt <= r_wcnt + 14'd1;
                    r_rem  <= r_rem - 16'd1;
                    // A byte here is byte 0 of the next word, unless this was
                    // the last word and the transfer is finishing.
                    if (bus.rx_valid_i && (r_rem != 16'd1)) begin
                        r_word[7:0] <= bus.rx_data_i;
                        r_bidx      <= 2'd1;
                        r_tmo       <= '0;
                    end else begin
                        r_bidx <= 2'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.upg_wen_o  = r_wen;
    assign bus.upg_adr_o  = r_adr;
    assign bus.upg_dat_o  = r_dat;
    assign bus.upg_done_o = r_done;
    assign bus.err_o      = r_err;
    assign bus.busy_o     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_upg_word_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_upg_word_loader
//  Purpose  : Self-checking bench for upg_word_loader: table of load
//             scenarios, hand-written corner sequences and randomized loads
//             checked against a byte-list reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_upg_word_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    upg_word_loader_if bus();

    upg_word_loader #(.TIMEOUT_CYC(50), .MAX_WORDS(16384)) dut (
        .upg_clk_i   (clk),
        .upg_rst_n_i (rst_n),
        .bus         (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc = cyc + 1;

    // Write-pulse monitor, sampled on the falling edge
    logic [13:0] q_adr[$];
    logic [31:0] q_dat[$];
    int          q_cyc[$];
    int          done_rise = -1;
    logic        prev_done = 1'b0;

    always @(negedge clk) begin
        if (bus.upg_wen_o === 1'b1) begin
            q_adr.push_back(bus.upg_adr_o);
            q_dat.push_back(bus.upg_dat_o);
            q_cyc.push_back(cyc);
        end
        if (bus.upg_done_o === 1'b1 && prev_done !== 1'b1) done_rise = cyc;
        prev_done = bus.upg_done_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_adr.delete();
        q_dat.delete();
        q_cyc.delete();
        done_rise = -1;
    endtask

    task automatic put_byte(input logic [7:0] b, input int gap);
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = b;
        tick();
        bus.rx_valid_i = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) put_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    typedef struct {
        logic [15:0] hdr;
        int          gap;
        int          nsent;
        logic [31:0] w0;
        logic [31:0] w1;
        int          exp_wr;
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    vec_t        tbl[5];
    logic [7:0]  bq[$];
    logic [31:0] ew;
    logic [31:0] bb_w[3];
    int          first_err;
    int          nw;

    initial begin
        tbl[0] = '{16'h0002, 15, 2, 32'h12345678, 32'hDEADBEEF, 2, 1'b1, 1'b0};
        tbl[1] = '{16'h0000,  1, 0, 32'h0,        32'h0,        0, 1'b1, 1'b0};
        tbl[2] = '{16'h4001,  1, 0, 32'h0,        32'h0,        0, 1'b0, 1'b1};
        tbl[3] = '{16'h0001,  0, 1, 32'hA5A55A5A, 32'h0,        1, 1'b1, 1'b0};
        tbl[4] = '{16'h0002,  2, 2, 32'h00000000, 32'hFFFFFFFF, 2, 1'b1, 1'b0};

        rst_n          = 1'b0;
        bus.start_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        bus.rx_data_i  = 8'h00;
        repeat (3) tick();
        chk("rst_wen",  bus.upg_wen_o,  0);
        chk("rst_adr",  bus.upg_adr_o,  0);
        chk("rst_dat",  bus.upg_dat_o,  0);
        chk("rst_flags", {bus.upg_done_o, bus.err_o, bus.busy_o}, 0);
        rst_n = 1'b1;
        tick();

        // Bytes in IDLE are dropped
        clear_mon();
        put_byte(8'h01, 1);
        put_byte(8'h00, 1);
        chk("idle_busy", bus.busy_o, 0);

        // start together with a byte in IDLE: byte dropped
        bus.start_i    = 1'b1;
        bus.rx_valid_i = 1'b1;
        bus.rx_data_i  = 8'h00;
        tick();
        bus.start_i    = 1'b0;
        bus.rx_valid_i = 1'b0;
        put_byte(8'h01, 1);
        put_byte(8'h00, 1);
        send_word(32'h11223344, 1);
        repeat (4) tick();
        chk("stbyte_nwr", q_adr.size(), 1);
        if (q_adr.size() >= 1) chk("stbyte_dat", q_dat[0], 32'h11223344);
        chk("stbyte_done", bus.upg_done_o, 1);

        // Table-driven loads
        for (int i = 0; i < 5; i++) begin
            clear_mon();
            pulse_start();
            put_byte(tbl[i].hdr[7:0], tbl[i].gap);
            put_byte(tbl[i].hdr[15:8], tbl[i].gap);
            if (tbl[i].nsent >= 1) send_word(tbl[i].w0, tbl[i].gap);
            if (tbl[i].nsent >= 2) send_word(tbl[i].w1, tbl[i].gap);
            repeat (4) tick();
            chk($sformatf("tbl%0d_nwr", i), q_adr.size(), tbl[i].exp_wr);
            for (int j = 0; j < q_adr.size() && j < tbl[i].exp_wr; j++) begin
                chk($sformatf("tbl%0d_adr%0d", i, j), q_adr[j], j);
                chk($sformatf("tbl%0d_dat%0d", i, j), q_dat[j], (j == 0) ? tbl[i].w0 : tbl[i].w1);
            end
            chk($sformatf("tbl%0d_done", i), bus.upg_done_o, tbl[i].exp_done);
            chk($sformatf("tbl%0d_err", i),  bus.err_o,      tbl[i].exp_err);
            chk($sformatf("tbl%0d_busy", i), bus.busy_o,     0);
            if (q_cyc.size() > 0)
                chk($sformatf("tbl%0d_donelat", i), done_rise, q_cyc[q_cyc.size()-1] + 1);
        end

        // Back-to-back bytes, count 3
        bb_w[0] = 32'h04030201;
        bb_w[1] = 32'h08070605;
        bb_w[2] = 32'h0C0B0A09;
        clear_mon();
        pulse_start();
        put_byte(8'h03, 0);
        put_byte(8'h00, 0);
        for (int i = 0; i < 3; i++) send_word(bb_w[i], 0);
        repeat (4) tick();
        chk("b2b_nwr", q_adr.size(), 3);
        for (int i = 0; i < q_adr.size() && i < 3; i++) begin
            chk($sformatf("b2b_adr%0d", i), q_adr[i], i);
            chk($sformatf("b2b_dat%0d", i), q_dat[i], bb_w[i]);
            if (i > 0) chk($sformatf("b2b_gap%0d", i), q_cyc[i] - q_cyc[i-1], 4);
        end
        chk("b2b_done", bus.upg_done_o, 1);

        // Reload from DONE: word counter restarts at 0
        clear_mon();
        pulse_start();
        chk("reload_done_drop", bus.upg_done_o, 0);
        put_byte(8'h01, 1);
        put_byte(8'h00, 1);
        send_word(32'h5A5AA5A5, 1);
        repeat (4) tick();
        chk("reload_nwr", q_adr.size(), 1);
        if (q_adr.size() >= 1) begin
            chk("reload_adr", q_adr[0], 0);
            chk("reload_dat", q_dat[0], 32'h5A5AA5A5);
        end
        chk("reload_done", bus.upg_done_o, 1);

        // Timeout after a partial word
        clear_mon();
        pulse_start();
        put_byte(8'h01, 1);
        put_byte(8'h00, 1);
        put_byte(8'h11, 1);
        put_byte(8'h22, 0);
        first_err = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (bus.err_o === 1'b1 && first_err < 0) first_err = k;
        end
        chk("tmo_latency", first_err, 50);
        chk("tmo_nwr", q_adr.size(), 0);
        chk("tmo_err_held", bus.err_o, 1);
        chk("tmo_done", bus.upg_done_o, 0);
        pulse_start();
        chk("tmo_err_clr", bus.err_o, 0);
        chk("tmo_busy", bus.busy_o, 1);
        put_byte(8'h00, 0);
        put_byte(8'h00, 0);
        tick();

        // Randomized loads against the byte-list model
        for (int r = 0; r < 30; r++) begin
            clear_mon();
            if ($urandom_range(0, 1) == 1) put_byte(8'($urandom), 1);
            nw = $urandom_range(1, 6);
            bq.delete();
            bq.push_back(8'(nw));
            bq.push_back(8'h00);
            for (int i = 0; i < 4 * nw; i++) bq.push_back(8'($urandom));
            pulse_start();
            foreach (bq[i]) put_byte(bq[i], $urandom_range(0, 3));
            repeat (4) tick();
            chk($sformatf("rnd%0d_nwr", r), q_adr.size(), nw);
            for (int i = 0; i < q_adr.size() && i < nw; i++) begin
                ew = 32'(bq[2+4*i]) + (32'(bq[3+4*i]) << 8) +
                     (32'(bq[4+4*i]) << 16) + (32'(bq[5+4*i]) << 24);
                chk($sformatf("rnd%0d_adr%0d", r, i), q_adr[i], i);
                chk($sformatf("rnd%0d_dat%0d", r, i), q_dat[i], ew);
            end
            chk($sformatf("rnd%0d_done", r), bus.upg_done_o, 1);
        end

        // Asynchronous reset mid-word
        clear_mon();
        pulse_start();
        put_byte(8'h01, 0);
        put_byte(8'h00, 0);
        put_byte(8'hAA, 2);
        put_byte(8'hBB, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_wen", bus.upg_wen_o, 0);
        chk("mrst_adr", bus.upg_adr_o, 0);
        chk("mrst_dat", bus.upg_dat_o, 0);
        chk("mrst_flags", {bus.upg_done_o, bus.err_o, bus.busy_o}, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        put_byte(8'h01, 0);
        put_byte(8'h00, 0);
        send_word(32'h44332211, 0);
        repeat (4) tick();
        chk("mrst_ign_nwr", q_adr.size(), 0);
        chk("mrst_ign_busy", bus.busy_o, 0);
        chk("mrst_ign_done", bus.upg_done_o, 0);
        pulse_start();
        put_byte(8'h01, 1);
        put_byte(8'h00, 1);
        send_word(32'hCAFEF00D, 1);
        repeat (4) tick();
        chk("mrst_after_nwr", q_adr.size(), 1);
        if (q_adr.size() >= 1) begin
            chk("mrst_after_adr", q_adr[0], 0);
            chk("mrst_after_dat", q_dat[0], 32'hCAFEF00D);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
